// File: rtl/crc_frame_tx_if.sv
// Byte-stream handshake into the CRC frame transmitter.
// The source drives data/valid/last and the transmitter answers with ready.
interface crc_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;

  modport master (
    output in_data,
    output in_valid,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/crc_frame_tx.sv
// Serialises a byte stream MSB-first through an external serial CRC engine,
// then appends the engine result as a CRC_LEN-bit trailer.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | ready for the first word of a frame
// S_CLR    | one-cycle engine clear
// S_DATA   | shifting payload bits to line and engine
// S_WAIT   | between words, engine held, waiting for next word
// S_PAD    | CRC_LEN zero bits into the engine, line silent
// S_SETTLE | engine idle for a cycle; result captured at its end
// S_TRAIL  | shifting the captured CRC out on the line
// S_DONE   | one-cycle frame completion pulse
module crc_frame_tx #(
  parameter int CRC_LEN = 32,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk_in,
  input  logic               reset_n,
  crc_frame_tx_if.slave      in_s,
  output logic               crc_clear,
  output logic               crc_enable,
  output logic               crc_data,
  input  logic [CRC_LEN-1:0] crc_value,
  output logic               tx_bit,
  output logic               tx_valid,
  output logic               tx_last,
  output logic               frame_done,
  output logic [CNT_W-1:0]   frame_words
);

  localparam int MAX_LEN = (CRC_LEN > DATA_W) ? CRC_LEN : DATA_W;
  localparam int CW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [CW-1:0] DATA_TOP = CW'(DATA_W - 1);
  localparam logic [CW-1:0] CRC_TOP  = CW'(CRC_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_DATA, S_WAIT, S_PAD, S_SETTLE, S_TRAIL, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0]    shift_q, shift_d;
  logic                 last_q, last_d;
  logic [CRC_LEN-1:0]   trail_q, trail_d;
  logic [CNT_W-1:0]     words_q, words_d, words_inc;

  logic in_ready_q, in_ready_d;
  logic crc_clear_q, crc_clear_d;
  logic crc_enable_q, crc_enable_d;
  logic crc_data_q, crc_data_d;
  logic tx_bit_q, tx_bit_d;
  logic tx_valid_q, tx_valid_d;
  logic tx_last_q, tx_last_d;
  logic frame_done_q, frame_done_d;
  logic accept;

  assign words_inc = (&words_q) ? words_q : words_q + CNT_W'(1);

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      last_q       <= 1'b0;
      trail_q      <= '0;
      words_q      <= '0;
      in_ready_q   <= 1'b0;
      crc_clear_q  <= 1'b0;
      crc_enable_q <= 1'b0;
      crc_data_q   <= 1'b0;
      tx_bit_q     <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_last_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      last_q       <= last_d;
      trail_q      <= trail_d;
      words_q      <= words_d;
      in_ready_q   <= in_ready_d;
      crc_clear_q  <= crc_clear_d;
      crc_enable_q <= crc_enable_d;
      crc_data_q   <= crc_data_d;
      tx_bit_q     <= tx_bit_d;
      tx_valid_q   <= tx_valid_d;
      tx_last_q    <= tx_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    last_d  = last_q;
    trail_d = trail_q;
    words_d = words_q;
    accept  = in_s.in_valid & in_ready_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          shift_d = in_s.in_data;
          last_d  = in_s.in_last;
          words_d = CNT_W'(1);
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        cnt_d   = DATA_TOP;
        state_d = S_DATA;
      end
      S_DATA: begin
        if (cnt_q != '0) begin
          cnt_d   = cnt_q - CW'(1);
          shift_d = shift_q << 1;
        end else if (last_q) begin
          cnt_d   = CRC_TOP;
          state_d = S_PAD;
        end else if (accept) begin
          // gapless reload: next word's MSB goes out on the very next cycle
          shift_d = in_s.in_data;
          last_d  = in_s.in_last;
          words_d = words_inc;
          cnt_d   = DATA_TOP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (accept) begin
          shift_d = in_s.in_data;
          last_d  = in_s.in_last;
          words_d = words_inc;
          cnt_d   = DATA_TOP;
          state_d = S_DATA;
        end
      end
      S_PAD: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        else             state_d = S_SETTLE;
      end
      S_SETTLE: begin
        trail_d = crc_value;
        cnt_d   = CRC_TOP;
        state_d = S_TRAIL;
      end
      S_TRAIL: begin
        if (cnt_q != '0) begin
          cnt_d   = cnt_q - CW'(1);
          trail_d = trail_q << 1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // outputs are decoded from next-state values so the registers line up with the state
    in_ready_d   = (state_d == S_IDLE) || (state_d == S_WAIT) ||
                   ((state_d == S_DATA) && (cnt_d == '0) && !last_d);
    crc_clear_d  = (state_d == S_CLR);
    crc_enable_d = (state_d == S_DATA) || (state_d == S_PAD);
    crc_data_d   = (state_d == S_DATA) && shift_d[DATA_W-1];
    tx_valid_d   = (state_d == S_DATA) || (state_d == S_TRAIL);
    tx_bit_d     = ((state_d == S_DATA)  && shift_d[DATA_W-1]) ||
                   ((state_d == S_TRAIL) && trail_d[CRC_LEN-1]);
    tx_last_d    = (state_d == S_TRAIL) && (cnt_d == '0);
    frame_done_d = (state_d == S_DONE);
  end

  assign in_s.in_ready = in_ready_q;
  assign crc_clear     = crc_clear_q;
  assign crc_enable    = crc_enable_q;
  assign crc_data      = crc_data_q;
  assign tx_bit        = tx_bit_q;
  assign tx_valid      = tx_valid_q;
  assign tx_last       = tx_last_q;
  assign frame_done    = frame_done_q;
  assign frame_words   = words_q;

endmodule
